// File: rtl/carrier_mixer_accum.sv
// carrier_mixer_accum
//   Carrier wipe-off and integrate-and-dump for one tracking channel.
//   The 2-bit sign/magnitude IF sample is multiplied by the I and Q carrier
//   from the NCO. The products are summed with saturation over an
//   integration interval. Each dump presents the sums, the qualified-sample
//   count and a sticky saturation flag.
//
//   Pipeline:
//     stage 1 : IF x carrier products, sample_en and dump_enable registered
//     stage 2 : accumulate, or close the interval into the output registers
//   dump_valid is registered on the clock edge that follows the edge which
//   sampled dump_enable.
//
// Ports
//   clk          sample clock
//   rstn         synchronous active-low reset
//   sample_en    qualifies the IF/carrier inputs this cycle
//   if_sign/mag  IF sample, sign 1 = positive, magnitude 0 -> 1, 1 -> 3
//   i_sign/mag   carrier I, sign 1 = positive, magnitude 0 -> 1, 1 -> 2
//   q_sign/mag   carrier Q, sign 1 = positive, magnitude 0 -> 1, 1 -> 2
//   dump_enable  end-of-interval strobe, aligned with the last sample to include
//   i_acc/q_acc  signed sums of the last completed interval
//   sample_cnt   qualified samples in the last completed interval
//   overflow     saturation occurred during the last completed interval
//   dump_valid   one-cycle pulse when the outputs update

module carrier_mixer_accum #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sample_en,
  input  logic                    if_sign,
  input  logic                    if_mag,
  input  logic                    i_sign,
  input  logic                    i_mag,
  input  logic                    q_sign,
  input  logic                    q_mag,
  input  logic                    dump_enable,
  output logic signed [ACC_W-1:0] i_acc,
  output logic signed [ACC_W-1:0] q_acc,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic                    overflow,
  output logic                    dump_valid
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

  // Stage 1: decoded operands and products
  logic signed [2:0] w_ifv;
  logic signed [2:0] w_cvi;
  logic signed [2:0] w_cvq;
  logic signed [3:0] w_pi;
  logic signed [3:0] w_pq;

  logic signed [3:0] r_p_i;
  logic signed [3:0] r_p_q;
  logic              r_p_valid;
  logic              r_d_dump;

  // Stage 2: running interval state
  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sticky;

  logic signed [3:0]       w_add_i;
  logic signed [3:0]       w_add_q;
  logic signed [ACC_W:0]   w_sum_i;
  logic signed [ACC_W:0]   w_sum_q;
  logic                    w_ovf_i;
  logic                    w_ovf_q;
  logic signed [ACC_W-1:0] w_sat_i;
  logic signed [ACC_W-1:0] w_sat_q;
  logic [CNT_W-1:0]        w_cnt_next;

  // Sign/magnitude decode: IF is +-1/+-3, carrier is +-1/+-2.
  always_comb begin
    w_ifv = if_mag ? 3'sd3 : 3'sd1;
    if (!if_sign) w_ifv = -w_ifv;
    w_cvi = i_mag ? 3'sd2 : 3'sd1;
    if (!i_sign) w_cvi = -w_cvi;
    w_cvq = q_mag ? 3'sd2 : 3'sd1;
    if (!q_sign) w_cvq = -w_cvq;
  end

  // |product| <= 6, so a 4-bit signed result is exact.
  assign w_pi = $signed({w_ifv[2], w_ifv}) * $signed({w_cvi[2], w_cvi});
  assign w_pq = $signed({w_ifv[2], w_ifv}) * $signed({w_cvq[2], w_cvq});

  // A non-qualified cycle contributes nothing, including on the dump cycle.
  assign w_add_i = r_p_valid ? r_p_i : 4'sd0;
  assign w_add_q = r_p_valid ? r_p_q : 4'sd0;

  // One guard bit: the sum overflowed when the top two bits disagree.
  assign w_sum_i = $signed({r_acc_i[ACC_W-1], r_acc_i})
                 + $signed({{(ACC_W-3){w_add_i[3]}}, w_add_i});
  assign w_sum_q = $signed({r_acc_q[ACC_W-1], r_acc_q})
                 + $signed({{(ACC_W-3){w_add_q[3]}}, w_add_q});

  assign w_ovf_i = w_sum_i[ACC_W] ^ w_sum_i[ACC_W-1];
  assign w_ovf_q = w_sum_q[ACC_W] ^ w_sum_q[ACC_W-1];

  always_comb begin
    w_sat_i = w_sum_i[ACC_W-1:0];
    if (w_ovf_i) w_sat_i = w_sum_i[ACC_W] ? ACC_MIN : ACC_MAX;
    w_sat_q = w_sum_q[ACC_W-1:0];
    if (w_ovf_q) w_sat_q = w_sum_q[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  // Sample counter sticks at all-ones rather than wrapping.
  assign w_cnt_next = (r_p_valid && (r_cnt != CNT_MAX)) ? r_cnt + 1'b1 : r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_p_i      <= '0;
      r_p_q      <= '0;
      r_p_valid  <= 1'b0;
      r_d_dump   <= 1'b0;
      r_acc_i    <= '0;
      r_acc_q    <= '0;
      r_cnt      <= '0;
      r_sticky   <= 1'b0;
      i_acc      <= '0;
      q_acc      <= '0;
      sample_cnt <= '0;
      overflow   <= 1'b0;
      dump_valid <= 1'b0;
    end else begin
      r_p_i      <= w_pi;
      r_p_q      <= w_pq;
      r_p_valid  <= sample_en;
      r_d_dump   <= dump_enable;
      dump_valid <= 1'b0;

      if (r_d_dump) begin
        // Close the interval, folding in the sample that came with the dump,
        // and start the next interval empty.
        i_acc      <= w_sat_i;
        q_acc      <= w_sat_q;
        sample_cnt <= w_cnt_next;
        overflow   <= r_sticky | w_ovf_i | w_ovf_q;
        dump_valid <= 1'b1;
        r_acc_i    <= '0;
        r_acc_q    <= '0;
        r_cnt      <= '0;
        r_sticky   <= 1'b0;
      end else if (r_p_valid) begin
        // Saturated sums keep accumulating from the clamped value.
        r_acc_i  <= w_sat_i;
        r_acc_q  <= w_sat_q;
        r_cnt    <= w_cnt_next;
        r_sticky <= r_sticky | w_ovf_i | w_ovf_q;
      end
    end
  end

endmodule
